// File: rtl/btb_update_writer.sv
// rtl/btb_update_writer.sv - BTB write side: hashed update queue plus ASID flush invalidate sweep
module btb_update_writer #(
  parameter int BTB_INDEX_WIDTH                = 7,
  parameter int LOG_BTB_NWAY_ENTRIES_PER_BLOCK = 3,
  parameter int BTB_TAG_WIDTH                  = 8,
  parameter int ASID_WIDTH                     = 9,
  parameter int QUEUE_DEPTH                    = 4
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      update_valid,
  input  logic [31:0]                               update_PC,
  input  logic [ASID_WIDTH-1:0]                     update_ASID,
  input  logic [31:0]                               update_target_PC,
  output logic                                      update_ready,
  input  logic                                      flush_req,
  output logic                                      flush_done,
  output logic                                      btb_write_valid,
  output logic [BTB_INDEX_WIDTH-1:0]                btb_write_index,
  output logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] btb_write_entry,
  output logic [BTB_TAG_WIDTH-1:0]                  btb_write_tag,
  output logic [31:0]                               btb_write_target,
  output logic                                      btb_write_invalidate,
  input  logic                                      btb_write_ready
);

  localparam int L  = LOG_BTB_NWAY_ENTRIES_PER_BLOCK;
  localparam int I  = BTB_INDEX_WIDTH;
  localparam int T  = BTB_TAG_WIDTH;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(QUEUE_DEPTH);
  localparam logic [I-1:0]  SWEEP_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;

  state_t         state_q;
  logic [I-1:0]   sweep_q;
  logic [QW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q, count_d;

  logic [I-1:0]   q_index_q  [QUEUE_DEPTH];
  logic [L-1:0]   q_entry_q  [QUEUE_DEPTH];
  logic [T-1:0]   q_tag_q    [QUEUE_DEPTH];
  logic [31:0]    q_target_q [QUEUE_DEPTH];

  // Same PC/ASID hash as the fetch-side lookup, so written entries are found later.
  logic [I-1:0]   asid_ext;
  logic [I-1:0]   enq_index;
  logic [L-1:0]   enq_entry;
  logic [T-1:0]   enq_tag;
  logic           unused_pc;

  generate
    if (ASID_WIDTH >= I) begin : g_asid_trunc
      assign asid_ext = update_ASID[I-1:0];
      if (ASID_WIDTH > I) begin : g_asid_high
        logic unused_asid;
        assign unused_asid = ^update_ASID[ASID_WIDTH-1:I];
      end
    end else begin : g_asid_zext
      assign asid_ext = {{(I-ASID_WIDTH){1'b0}}, update_ASID};
    end
  endgenerate

  assign enq_index = update_PC[I+L:L+1] ^ asid_ext;
  assign enq_entry = update_PC[L:1];
  assign enq_tag   = update_PC[T+I+L:I+L+1];
  assign unused_pc = ^{update_PC[31:T+I+L+1], update_PC[0]};

  logic enq, deq;

  // Ready never looks at the array grant, so a full queue blocks even while draining.
  assign update_ready = (state_q == S_IDLE) && (count_q < DEPTH_C) && !flush_req;
  assign enq          = update_valid && update_ready;
  assign deq          = (state_q == S_IDLE) && (count_q != '0) && btb_write_ready;
  assign flush_done   = (state_q == S_DONE);

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Update queue: a flush drops everything queued, since it belongs to the old context.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_index_q[i]  <= '0;
        q_entry_q[i]  <= '0;
        q_tag_q[i]    <= '0;
        q_target_q[i] <= '0;
      end
    end else if (state_q == S_IDLE && flush_req) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        q_index_q[tail_q]  <= enq_index;
        q_entry_q[tail_q]  <= enq_entry;
        q_tag_q[tail_q]    <= enq_tag;
        q_target_q[tail_q] <= update_target_PC;
        tail_q             <= tail_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Flush FSM: sweep every set once, pulse done, and restart on a new flush request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            state_q <= S_FLUSH;
            sweep_q <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_req) begin
            sweep_q <= '0;
          end else if (btb_write_ready) begin
            if (sweep_q == SWEEP_LAST) begin
              state_q <= S_DONE;
              sweep_q <= '0;
            end else begin
              sweep_q <= sweep_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          sweep_q <= '0;
          state_q <= flush_req ? S_FLUSH : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          sweep_q <= '0;
        end
      endcase
    end
  end

  // Write port mux: sweep invalidates while flushing, otherwise the queue head.
  always_comb begin
    btb_write_valid      = 1'b0;
    btb_write_invalidate = 1'b0;
    btb_write_index      = '0;
    btb_write_entry      = '0;
    btb_write_tag        = '0;
    btb_write_target     = '0;
    if (state_q == S_FLUSH) begin
      btb_write_valid      = 1'b1;
      btb_write_invalidate = 1'b1;
      btb_write_index      = sweep_q;
    end else if (state_q == S_IDLE && count_q != '0) begin
      btb_write_valid  = 1'b1;
      btb_write_index  = q_index_q[head_q];
      btb_write_entry  = q_entry_q[head_q];
      btb_write_tag    = q_tag_q[head_q];
      btb_write_target = q_target_q[head_q];
    end
  end

endmodule

// File: tb/tb_btb_update_writer.sv
// tb/tb_btb_update_writer.sv - directed self-checking bench for btb_update_writer
module tb_btb_update_writer;

  logic        CLK;
  logic        nRST;
  logic        update_valid;
  logic [31:0] update_PC;
  logic [8:0]  update_ASID;
  logic [31:0] update_target_PC;
  logic        update_ready;
  logic        flush_req;
  logic        flush_done;
  logic        btb_write_valid;
  logic [6:0]  btb_write_index;
  logic [2:0]  btb_write_entry;
  logic [7:0]  btb_write_tag;
  logic [31:0] btb_write_target;
  logic        btb_write_invalidate;
  logic        btb_write_ready;

  int checks;
  int failures;

  btb_update_writer dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .update_valid         (update_valid),
    .update_PC            (update_PC),
    .update_ASID          (update_ASID),
    .update_target_PC     (update_target_PC),
    .update_ready         (update_ready),
    .flush_req            (flush_req),
    .flush_done           (flush_done),
    .btb_write_valid      (btb_write_valid),
    .btb_write_index      (btb_write_index),
    .btb_write_entry      (btb_write_entry),
    .btb_write_tag        (btb_write_tag),
    .btb_write_target     (btb_write_target),
    .btb_write_invalidate (btb_write_invalidate),
    .btb_write_ready      (btb_write_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [8:0] asid, input logic [31:0] tgt);
    update_valid     = 1'b1;
    update_PC        = pc;
    update_ASID      = asid;
    update_target_PC = tgt;
  endtask

  int bad_idx;
  int bad_inv;
  int bad_rdy;
  int done_seen;

  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0;
    update_valid = 1'b0;
    update_PC = '0;
    update_ASID = '0;
    update_target_PC = '0;
    flush_req = 1'b0;
    btb_write_ready = 1'b1;
    #1;
    check_eq("rst_valid", {31'd0, btb_write_valid}, 32'd0);
    check_eq("rst_done", {31'd0, flush_done}, 32'd0);
    check_eq("rst_inv", {31'd0, btb_write_invalidate}, 32'd0);
    repeat (2) step();
    nRST = 1'b1;
    step();
    check_eq("rst_ready", {31'd0, update_ready}, 32'd1);
    check_eq("rst_valid2", {31'd0, btb_write_valid}, 32'd0);

    // Basic hash and one-cycle latency
    offer(32'h0000_0A5E, 9'h003, 32'h0000_1000);
    #1;
    check_eq("t1_same_cycle_valid", {31'd0, btb_write_valid}, 32'd0);
    step();
    update_valid = 1'b0;
    #1;
    check_eq("t1_valid", {31'd0, btb_write_valid}, 32'd1);
    check_eq("t1_index", {25'd0, btb_write_index}, 32'h26);
    check_eq("t1_entry", {29'd0, btb_write_entry}, 32'd7);
    check_eq("t1_tag", {24'd0, btb_write_tag}, 32'h01);
    check_eq("t1_target", btb_write_target, 32'h0000_1000);
    check_eq("t1_inv", {31'd0, btb_write_invalidate}, 32'd0);
    step();
    check_eq("t1_drained", {31'd0, btb_write_valid}, 32'd0);

    // Full queue backpressure, then in-order drain
    btb_write_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'(2 * (i + 1)), 9'h000, 32'h2000 + 32'(i));
      #1;
      check_eq($sformatf("t2_ready%0d", i), {31'd0, update_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    update_valid = 1'b0;
    btb_write_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_valid%0d", i), {31'd0, btb_write_valid}, 32'd1);
      check_eq($sformatf("t2_target%0d", i), btb_write_target, 32'h2000 + 32'(i));
      check_eq($sformatf("t2_entry%0d", i), {29'd0, btb_write_entry}, 32'(i + 1));
      step();
    end
    check_eq("t2_empty", {31'd0, btb_write_valid}, 32'd0);

    // ASID folding into index
    offer(32'h0000_0A5E, 9'h000, 32'h0);
    step();
    update_valid = 1'b0;
    #1;
    check_eq("t3_asid000", {25'd0, btb_write_index}, 32'h25);
    step();
    offer(32'h0000_0A5E, 9'h07F, 32'h0);
    step();
    update_valid = 1'b0;
    #1;
    check_eq("t3_asid07f", {25'd0, btb_write_index}, 32'h5A);
    step();
    offer(32'h0000_0A5E, 9'h100, 32'h0);
    step();
    update_valid = 1'b0;
    #1;
    check_eq("t3_asid100", {25'd0, btb_write_index}, 32'h25);
    step();

    // Flush with two queued updates: queue dropped, full sweep
    btb_write_ready = 1'b0;
    offer(32'h0000_0100, 9'h001, 32'h3000);
    step();
    offer(32'h0000_0200, 9'h001, 32'h3004);
    step();
    update_valid = 1'b0;
    btb_write_ready = 1'b1;
    flush_req = 1'b1;
    #1;
    check_eq("t4_ready_on_req", {31'd0, update_ready}, 32'd0);
    step();
    flush_req = 1'b0;
    bad_idx = 0; bad_inv = 0; bad_rdy = 0; done_seen = 0;
    for (int k = 0; k < 128; k++) begin
      if (btb_write_index != 7'(k) || !btb_write_valid) bad_idx++;
      if (!btb_write_invalidate || btb_write_target != 0 || btb_write_entry != 0) bad_inv++;
      if (update_ready) bad_rdy++;
      if (flush_done) done_seen++;
      step();
    end
    check_eq("t4_sweep_index", 32'(bad_idx), 32'd0);
    check_eq("t4_sweep_inv", 32'(bad_inv), 32'd0);
    check_eq("t4_sweep_ready", 32'(bad_rdy), 32'd0);
    check_eq("t4_early_done", 32'(done_seen), 32'd0);
    check_eq("t4_done", {31'd0, flush_done}, 32'd1);
    check_eq("t4_done_valid", {31'd0, btb_write_valid}, 32'd0);
    step();
    check_eq("t4_done_pulse", {31'd0, flush_done}, 32'd0);
    check_eq("t4_queue_dropped", {31'd0, btb_write_valid}, 32'd0);
    check_eq("t4_ready_after", {31'd0, update_ready}, 32'd1);

    // Flush restart at counter 50, with a stall at counter 10
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin
        btb_write_ready = 1'b0;
        step();
        step();
        check_eq("t5_hold_index", {25'd0, btb_write_index}, 32'd10);
        check_eq("t5_hold_valid", {31'd0, btb_write_valid}, 32'd1);
        btb_write_ready = 1'b1;
      end
      step();
    end
    check_eq("t5_at50", {25'd0, btb_write_index}, 32'd50);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    bad_idx = 0; done_seen = 0;
    for (int k = 0; k < 128; k++) begin
      if (btb_write_index != 7'(k) || !btb_write_valid) bad_idx++;
      if (flush_done) done_seen++;
      step();
    end
    check_eq("t5_restart_index", 32'(bad_idx), 32'd0);
    check_eq("t5_early_done", 32'(done_seen), 32'd0);
    check_eq("t5_done", {31'd0, flush_done}, 32'd1);
    step();

    // Async reset mid-sweep
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (20) step();
    check_eq("t6_at20", {25'd0, btb_write_index}, 32'd20);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'd0, btb_write_valid}, 32'd0);
    check_eq("t6_rst_inv", {31'd0, btb_write_invalidate}, 32'd0);
    check_eq("t6_rst_index", {25'd0, btb_write_index}, 32'd0);
    check_eq("t6_rst_done", {31'd0, flush_done}, 32'd0);
    step();
    nRST = 1'b1;
    step();
    check_eq("t6_ready", {31'd0, update_ready}, 32'd1);
    done_seen = 0;
    bad_idx = 0;
    for (int k = 0; k < 140; k++) begin
      if (flush_done) done_seen++;
      if (btb_write_valid) bad_idx++;
      step();
    end
    check_eq("t6_no_done", 32'(done_seen), 32'd0);
    check_eq("t6_idle", 32'(bad_idx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_update_writer.md
Name: btb_update_writer

Overview:
- Write side of the BTB: buffers resolved-branch updates from the backend and drives the BTB array write port.
- Computes the write index with the same PC/ASID hash the fetch-side lookup uses, so written entries are found by later predictions.
- Performs a full-array invalidate sweep on an ASID flush request.
- Sits between branch resolution and the BTB array; the array arbiter gives fetch reads priority over this block's writes.

Parameters:
- BTB_INDEX_WIDTH, 7, index bits (array has 2^7 sets)
- LOG_BTB_NWAY_ENTRIES_PER_BLOCK, 3, log2 entries per fetch block (8)
- BTB_TAG_WIDTH, 8, tag bits stored per entry
- ASID_WIDTH, 9, ASID width
- QUEUE_DEPTH, 4, update queue entries (power of 2)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- update_valid  in  1  backend update request
- update_PC  in  32  branch PC
- update_ASID  in  ASID_WIDTH  current ASID
- update_target_PC  in  32  resolved target
- update_ready  out  1  queue can accept
- flush_req  in  1  one-cycle pulse: invalidate all BTB entries
- flush_done  out  1  one-cycle pulse: sweep complete
- btb_write_valid  out  1  write request to array
- btb_write_index  out  BTB_INDEX_WIDTH  set index
- btb_write_entry  out  LOG_BTB_NWAY_ENTRIES_PER_BLOCK  entry within set
- btb_write_tag  out  BTB_TAG_WIDTH  tag
- btb_write_target  out  32  target PC
- btb_write_invalidate  out  1  1 = clear all entries of the set (sweep)
- btb_write_ready  in  1  arbiter grant (0 when fetch read wins)

Behaviour:
- L = LOG_BTB_NWAY_ENTRIES_PER_BLOCK, I = BTB_INDEX_WIDTH.
- Hash computed at enqueue and stored in the queue:
  - index = PC[I+L : L+1] XOR ASID[I-1:0]
  - if ASID_WIDTH < I, ASID is zero-extended
  - entry = PC[L:1]
  - tag = PC[BTB_TAG_WIDTH+I+L : I+L+1]
  - target stored verbatim.
- Reset (async, nRST=0): queue empty, head/tail/count=0, state IDLE, sweep counter 0. All outputs 0 except update_ready=1 once out of reset.
- update_ready = (state==IDLE) & (count<QUEUE_DEPTH) & ~flush_req.
- Enqueue on update_valid & update_ready.
- Head drives the write port directly from queue registers: btb_write_valid = (state==IDLE) & (count>0), invalidate=0.
- Dequeue on btb_write_valid & btb_write_ready.
- Latency: an update accepted in cycle N presents on the write port no earlier than N+1. Back-to-back throughput is 1/cycle when granted.
- Simultaneous enqueue and dequeue when full: allowed only if update_ready; full blocks enqueue even if dequeueing that cycle (ready does not depend on btb_write_ready).
- Pointers wrap modulo QUEUE_DEPTH. Count saturates at 0/QUEUE_DEPTH by construction.
- FSM:
  - IDLE: on flush_req → FLUSH. All queued updates are discarded (count=0); they belong to the old context. Sweep counter is set to 0.
  - FLUSH: btb_write_valid=1, invalidate=1, index=sweep counter, entry/tag/target=0. Counter increments on btb_write_ready. On grant with counter = 2^I−1 → DONE.
  - DONE: flush_done=1 for exactly one cycle → IDLE.
- flush_req during FLUSH: counter restarts at 0.
- flush_req during DONE: flush_done still pulses, then go directly to FLUSH with counter 0.
- Write port holds stable while btb_write_valid=1 and btb_write_ready=0.
- Async reset mid-sweep or mid-queue: all state cleared immediately; no flush_done pulse.

Test Plan:
- Reset, then update PC=0x00000A5E, ASID=0x003, target=0x00001000, btb_write_ready=1 → next cycle write_valid=1, index=0x26, entry=7, tag=0x01, target=0x00001000, invalidate=0.
- Hold btb_write_ready=0, offer 5 back-to-back updates → first 4 accepted, update_ready=0 on 5th. Release ready → 4 writes in enqueue order on consecutive cycles.
- Same PC=0x00000A5E with ASID=0x000 vs ASID=0x07F → index 0x25 vs 0x5A; ASID=0x100 → index 0x25 (bit 8 ignored).
- Queue holding 2 updates, flush_req pulse, btb_write_ready=1 → queue dropped, 128 invalidate writes, index 0..127 in order. flush_done high one cycle after index 127. update_ready=0 throughout.
- flush_req again when sweep counter = 50 → counter restarts at 0; total 128 further writes before flush_done.
- Assert nRST at counter = 20 → outputs 0 asynchronously; after release state IDLE, update_ready=1, flush_done never pulses.
